// File: rtl/pll_lock_seq.sv
// PLL lock qualifier: turns a raw PLL lock into a clean core reset and a fractional clock enable.
// Optional lock-loss counter is enabled by defining PLL_LOCK_SEQ_LOSS_COUNT_EN.
module pll_lock_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256,
  parameter int CE_NUM        = 8,
  parameter int CE_DEN        = 110,
  parameter int ACC_W         = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       reset_out,
  output logic       running,
  output logic       ce_out,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ACC_W-1:0] NUM_A       = ACC_W'(CE_NUM);
  localparam logic [ACC_W-1:0] DEN_A       = ACC_W'(CE_DEN);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [1:0]       sync_q, sync_d;
  logic             lk_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_s;
  logic             reset_out_q, reset_out_d;
  logic             running_q, running_d;
  logic             ce_q, ce_d;

  assign lk_s = sync_q[1];

  // Next-state, shared counter and fractional-enable accumulator
  always_comb begin
    sync_d  = {sync_q[0], pll_locked};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    reset_out_d = (state_d != RUN);
    running_d   = (state_d == RUN);

    // The accumulator only runs while the next state is RUN, so it clears as running falls.
    sum_s = acc_q + NUM_A;
    if (state_d == RUN) begin
      if (sum_s >= DEN_A) begin
        acc_d = sum_s - DEN_A;
        ce_d  = 1'b1;
      end else begin
        acc_d = sum_s;
        ce_d  = 1'b0;
      end
    end else begin
      acc_d = '0;
      ce_d  = 1'b0;
    end
  end

  // Synchroniser, FSM and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q      <= 2'b00;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      acc_q       <= '0;
      reset_out_q <= 1'b1;
      running_q   <= 1'b0;
      ce_q        <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      reset_out_q <= reset_out_d;
      running_q   <= running_d;
      ce_q        <= ce_d;
    end
  end

  assign reset_out = reset_out_q;
  assign running   = running_q;
  assign ce_out    = ce_q;

`ifdef PLL_LOCK_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q, loss_d;

  // Saturating count of lock drops seen while running
  always_comb begin
    if ((state_q == RUN) && !lk_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  // Loss counter register, cleared only by reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: qualification timing, glitch restart, enable pattern, lock loss, mid-sequence reset.
module tb_pll_lock_seq;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       reset_out, running, ce_out;
  logic [7:0] lock_loss_cnt;
  logic       reset_out2, running2, ce2;
  logic [7:0] lock_loss_cnt2;

  int checks = 0;
  int errors = 0;
  int n;
  int n2;
  int exp_loss = 0;
  logic [7:0] pat2;

`ifdef PLL_LOCK_SEQ_LOSS_COUNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  always #5 clk_sys = ~clk_sys;

  pll_lock_seq #(.STABLE_CYCLES(8), .HOLD_CYCLES(4), .CE_NUM(1), .CE_DEN(4), .ACC_W(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked),
    .reset_out(reset_out), .running(running), .ce_out(ce_out), .lock_loss_cnt(lock_loss_cnt)
  );

  pll_lock_seq #(.STABLE_CYCLES(8), .HOLD_CYCLES(4), .CE_NUM(3), .CE_DEN(8), .ACC_W(8)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked),
    .reset_out(reset_out2), .running(running2), .ce_out(ce2), .lock_loss_cnt(lock_loss_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk_sys);
    #1;
  endtask

  task automatic count_to_run(output int cyc);
    cyc = 0;
    while (running !== 1'b1 && cyc < 64) begin
      step(1);
      cyc++;
    end
  endtask

  // Drop lock from RUN; outputs react the cycle after lk_s falls
  task automatic lose_lock();
    pll_locked = 1'b0;
    step(3);
    if (LOSS_EN != 0 && exp_loss < 255) exp_loss++;
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    pat2       = 8'b1010_0100;
    step(3);
    reset = 1'b0;
    chk("rst_reset_out", 32'(reset_out), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ce", 32'(ce_out), 32'd0);
    chk("rst_loss", 32'(lock_loss_cnt), 32'd0);

    // First qualification
    pll_locked = 1'b1;
    step(1);
    chk("lk_s_lat1", 32'(dut.lk_s), 32'd0);
    step(1);
    chk("lk_s_lat2", 32'(dut.lk_s), 32'd1);
    count_to_run(n);
    chk("qual_cycles", 32'(n), 32'd13);
    chk("run_reset_out", 32'(reset_out), 32'd0);

    // Enable patterns from the first RUN cycle
    n2 = 0;
    for (int k = 1; k <= 16; k++) begin
      chk("ce_1of4", 32'(ce_out), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("ce_3of8", 32'(ce2), 32'(pat2[(k - 1) % 8]));
      if (ce2 === 1'b1) n2++;
      if (k < 16) step(1);
    end
    chk("ce_3of8_count", 32'(n2), 32'd6);

    // Lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    chk("loss_still_run", 32'(running), 32'd1);
    step(1);
    if (LOSS_EN != 0) exp_loss++;
    chk("loss_reset_out", 32'(reset_out), 32'd1);
    chk("loss_running", 32'(running), 32'd0);
    chk("loss_ce", 32'(ce_out), 32'd0);
    chk("loss_acc", 32'(dut.acc_q), 32'd0);
    chk("loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));

    // Single-cycle glitch in STABLE at cnt=5
    pll_locked = 1'b1;
    step(2);
    chk("glitch_lk_up", 32'(dut.lk_s), 32'd1);
    step(4);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("glitch_state_stable", 32'(dut.state_q), 32'd1);
    chk("glitch_cnt5", 32'(dut.cnt_q), 32'd5);
    step(1);
    chk("glitch_wait_lock", 32'(dut.state_q), 32'd0);
    chk("glitch_lk_back", 32'(dut.lk_s), 32'd1);
    count_to_run(n);
    chk("glitch_requal", 32'(n), 32'd13);

    // Reset during HOLD at cnt=2
    lose_lock();
    chk("loss2_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
    pll_locked = 1'b1;
    step(2);
    step(11);
    chk("hold_state", 32'(dut.state_q), 32'd2);
    chk("hold_cnt2", 32'(dut.cnt_q), 32'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_loss = 0;
    chk("hreset_state", 32'(dut.state_q), 32'd0);
    chk("hreset_cnt", 32'(dut.cnt_q), 32'd0);
    chk("hreset_reset_out", 32'(reset_out), 32'd1);
    chk("hreset_lk_s", 32'(dut.lk_s), 32'd0);
    chk("hreset_loss", 32'(lock_loss_cnt), 32'd0);
    step(2);
    chk("hreset_lk_up", 32'(dut.lk_s), 32'd1);
    count_to_run(n);
    chk("hreset_requal", 32'(n), 32'd13);

`ifdef PLL_LOCK_SEQ_LOSS_COUNT_EN
    // Saturation of the lock-loss counter
    for (int e = 0; e < 300; e++) begin
      lose_lock();
      pll_locked = 1'b1;
      step(2);
      count_to_run(n);
    end
    chk("sat_run", 32'(running), 32'd1);
    chk("sat_255", 32'(lock_loss_cnt), 32'd255);
    lose_lock();
    chk("sat_stays", 32'(lock_loss_cnt), 32'd255);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("sat_cleared", 32'(lock_loss_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
